// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine.
// Holds the FSM state encoding and the slice width.
package nibble_serial_adder_ctrl_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle for the nibble-serial adder.
// The slave modport is the engine's view; the master modport is the requester's view.
interface nibble_serial_adder_ctrl_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic             op_sub;
   logic             c_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
   logic             busy;

   modport slave (
      input  in_valid, op_sub, c_in, a, b, out_ready,
      output in_ready, out_valid, sum, c_out, ovf, busy
   );

   modport master (
      output in_valid, op_sub, c_in, a, b, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf, busy
   );

endinterface

// File: rtl/nibble_serial_adder_ctrl_add4.sv
// Combinational 4-bit ripple-carry adder slice built from 1-bit full adders.
// Shared by every nibble of a serial operation.
module nibble_add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract: one 4-bit slice walks the operands LSB nibble first,
// carrying between nibbles in carry_q. Fixed latency of WIDTH/4 RUN cycles.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   nibble_serial_adder_ctrl_if.slave  bus
);

   localparam int NIBBLES = WIDTH / NIB_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
   end

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_q, b_q, sum_q;
   logic               carry_q, c_out_q, ovf_q;
   logic [IDX_W-1:0]   idx;
   logic [NIB_W-1:0]   s_sum;
   logic               s_cout;
   logic               accept, last;
   logic [WIDTH+NIB_W-1:0] sum_cat;

   nibble_add4 u_slice (
      .a    (a_q[NIB_W-1:0]),
      .b    (b_q[NIB_W-1:0]),
      .cin  (carry_q),
      .sum  (s_sum),
      .cout (s_cout)
   );

   assign accept  = bus.in_valid && (state == IDLE);
   assign last    = (idx == IDX_W'(NIBBLES - 1));
   // New slice result enters at the top; after NIBBLES shifts the LSB nibble is at the bottom.
   assign sum_cat = {s_sum, sum_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         idx     <= '0;
      end else if (accept) begin
         // Subtract is a + ~b + 1; the inversion happens once here, not per nibble.
         a_q     <= bus.a;
         b_q     <= bus.op_sub ? ~bus.b : bus.b;
         carry_q <= bus.op_sub ? 1'b1 : bus.c_in;
         sum_q   <= '0;
         idx     <= '0;
      end else if (state == RUN) begin
         a_q     <= a_q >> NIB_W;
         b_q     <= b_q >> NIB_W;
         sum_q   <= sum_cat[WIDTH+NIB_W-1:NIB_W];
         carry_q <= s_cout;
         idx     <= idx + IDX_W'(1);
         if (last) begin
            c_out_q <= s_cout;
            ovf_q   <= (a_q[NIB_W-1] == b_q[NIB_W-1]) && (s_sum[NIB_W-1] != a_q[NIB_W-1]);
         end
      end
   end

   assign bus.sum   = sum_q;
   assign bus.c_out = c_out_q;
   assign bus.ovf   = ovf_q;

endmodule
